// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and arbitration helper for the UART TX arbiter
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT = 10400;
  localparam int FRAME_BITS       = 10;
  localparam int DATA_BITS        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Returns {any_valid, selected}; on a tie the requester that did not go last wins.
  function automatic logic [1:0] rr_pick(input logic v0, input logic v1, input logic last_grant);
    logic sel;
    sel = (v0 && v1) ? ~last_grant : v1;
    return {v0 | v1, sel};
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter emitting a one-cycle tick at count BAUD_DIV-1
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin arbiter feeding an 8N1 serializer
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_START = ST_START;
  localparam logic [1:0] S_DATA  = ST_DATA;
  localparam logic [1:0] S_STOP  = ST_STOP;

  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic                 tx_q, tx_d;

  logic [1:0] pick;
  logic       have_req;
  logic       sel;
  logic       hs;
  logic       bit_tick;

  assign pick     = rr_pick(req0_valid, req1_valid, last_grant_q);
  assign have_req = pick[1];
  assign sel      = pick[0];

  // Ready is gated by reset so neither requester sees an acceptance while the block is held.
  assign req0_ready = reset && (state_q == S_IDLE) && have_req && !sel;
  assign req1_ready = reset && (state_q == S_IDLE) && have_req && sel;
  assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .sysclk(sysclk),
    .reset (reset),
    .clr   (hs),
    .en    (state_q != S_IDLE),
    .tick  (bit_tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          shift_d      = sel ? req1_data : req0_data;
          grant_d      = sel;
          last_grant_d = sel;
          state_d      = S_START;
        end
      end
      S_START: begin
        if (bit_tick) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // tx is registered from the next state so the pin never glitches on state decode.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_q         <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line between two byte requesters. Round-robin arbitration, valid/ready handshake, and 8N1 frame serialization. Bit timing comes from an internal baud-tick counter running on the system clock, so no derived clocks leave the block. Sits between the CPU's UART peripheral and debug/monitor byte sources and the board TX pin.

## Interface
- BAUD_DIV, 10400: system-clock cycles per UART bit; legal range ≥ 2.
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte; must be stable while req0_valid is high.
- req0_ready  out  1  requester 0 byte accepted this cycle when req0_valid is also high.
- req1_valid, req1_data, req1_ready: same roles for requester 1.
- tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress (any state other than IDLE).
- grant_id  out  1  requester whose byte is currently (or was last) being sent.

## Operation
- States: IDLE, START, DATA, STOP.
- **IDLE**
  - tx=1, busy=0.
  - Select a requester:
    - only one valid: select it.
    - both valid: select the one ≠ last_grant.
    - none valid: no selection.
  - reqN_ready = (state==IDLE) && selected==N. Ready is combinational on valid. Never more than one ready high at a time.
  - Handshake (valid && ready): latch data into an 8-bit shift register, set grant_id=last_grant=N, clear the baud counter, go to START.
- **START**
  - tx=0 for one bit period, then go to DATA with bit_idx=0.
- **DATA**
  - tx = shift[0], sent LSB first.
  - At each bit-period end: shift right, bit_idx+1.
  - After bit_idx==7 completes, go to STOP.
- **STOP**
  - tx=1 for one bit period, then go to IDLE.
- Baud counter:
  - Width $clog2(BAUD_DIV).
  - Counts 0..BAUD_DIV-1 and wraps. Bit-period end is when it reaches BAUD_DIV-1.
  - Cleared on handshake. Does not count in IDLE.
- Dropping valid without a handshake is legal and has no effect.
- A requester that keeps valid high cannot starve the other: grants alternate whenever both are valid at IDLE.

## Timing
- Reset (reset=0), applied asynchronously:
  - tx=1, busy=0, req0_ready=req1_ready=0 (forced low while reset is asserted).
  - grant_id=0, last_grant=1 (requester 0 wins the first tie).
  - state=IDLE, counter=0, bit_idx=0.
- Reset mid-frame: frame aborts immediately and tx returns to 1. No partial byte is re-sent after release.
- Latency: tx falls on the first sysclk edge after the handshake edge. busy rises on the same edge.
- Frame length: exactly 10×BAUD_DIV cycles from the tx fall to IDLE re-entry.
- Back-to-back:
  - The next handshake can occur in the first IDLE cycle.
  - Minimum handshake-to-handshake spacing is 10×BAUD_DIV+1 cycles.
  - tx stays high for at least 1 cycle between frames.
- The unselected requester's ready stays 0 for the whole frame. Its valid/data must be held.

## Structure
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP);
  - default BAUD_DIV;
  - FRAME_BITS=10, DATA_BITS=8.
- One sub-module: uart_baud_tick.
  - Ports: sysclk, reset, clr, en, tick.
  - Emits a one-cycle tick at count BAUD_DIV-1.
- The arbiter/FSM/shift register stays in uart_tx_arbiter.

## Test plan
- BAUD_DIV=4; req0 sends 0xA5, req1 idle:
  - req0_ready pulses 1 cycle.
  - tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; busy high for 40 cycles.
  - grant_id=0.
- Both valid from reset (req0=0x11, req1=0x22):
  - 0x11 is sent first, then 0x22 handshakes in the first IDLE cycle after 40 cycles.
  - Grants alternate 0,1,0,1 over 4 frames with both held valid.
- req1 holds valid through an entire req0 frame:
  - req1_ready stays 0 until IDLE; req1_data is latched intact.
- reset pulled low at cycle 17 of a frame:
  - tx=1 and busy=0 in the same cycle without waiting for an edge.
  - After release, a new request from req1 is granted with no residue.
- Valid pulsed for 1 cycle while busy:
  - No handshake, no frame emitted afterward.
- BAUD_DIV=2 boundary:
  - Frame = 20 cycles.
  - Back-to-back frames separated by exactly 1 idle-high cycle.
